// File: rtl/vga_pixel_fetch.sv
// ----------------------------------------------------------------------------
// vga_pixel_fetch
// Feeds the framebuffer colour-conversion stage. On start_i it latches the
// frame configuration, then walks the frame one 32-bit word at a time over a
// Wishbone classic read master. Words land in a 2-entry FIFO. Each word is
// presented once per pixel it holds as {word, lane, depth} on a valid/ready
// handshake.
//
// Ports
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   start_i               frame start pulse: latches config, flushes state
//   color_depth_i         00=8bpp 01=16bpp 10=32bpp 11=invalid
//   base_addr_i           frame base byte address (low two bits ignored)
//   frame_pixels_i        pixels in the frame
//   wbm_*                 Wishbone classic read master
//   mem_o/mem_lsb_o       FIFO head word and pixel lane within it
//   color_depth_o         latched depth
//   pix_valid_o/ready_i   pixel handshake
//   underrun_o            consumer ready but no word buffered yet
//   frame_done_o          last pixel accepted (held until next start_i)
//   cfg_err_o             latched depth is the invalid code
// ----------------------------------------------------------------------------
module vga_pixel_fetch #(
    parameter int PIXCNT_W = 20,
    parameter int ADDR_W   = 32
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                start_i,
    input  logic [1:0]          color_depth_i,
    input  logic [ADDR_W-1:0]   base_addr_i,
    input  logic [PIXCNT_W-1:0] frame_pixels_i,
    output logic [ADDR_W-1:0]   wbm_adr_o,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [3:0]          wbm_sel_o,
    input  logic [31:0]         wbm_dat_i,
    input  logic                wbm_ack_i,
    output logic [31:0]         mem_o,
    output logic [1:0]          mem_lsb_o,
    output logic [1:0]          color_depth_o,
    output logic                pix_valid_o,
    input  logic                pix_ready_i,
    output logic                underrun_o,
    output logic                frame_done_o,
    output logic                cfg_err_o
);

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t                r_state, w_state_nxt;
    logic [1:0]            r_depth;
    logic [ADDR_W-1:0]     r_addr;       // next word to fetch
    logic [ADDR_W-1:0]     r_req_adr;    // address of the cycle on the bus
    logic [PIXCNT_W-1:0]   r_words_left;
    logic [PIXCNT_W-1:0]   r_pix_left;
    logic                  r_active;
    logic                  r_done;
    logic                  r_flush;      // in-flight read belongs to an old frame
    logic [31:0]           r_fifo [2];
    logic                  r_rptr, r_wptr;
    logic [1:0]            r_cnt;
    logic [1:0]            r_lane;

    logic [PIXCNT_W+1:0]   w_npix, w_words_ext;
    logic [PIXCNT_W-1:0]   w_words_init;
    logic [1:0]            w_lane_max;
    logic                  w_valid, w_fire, w_pop, w_last, w_ack, w_push, w_launch;

    // Words needed for the frame: round-up divide by pixels-per-word.
    always_comb begin
        w_npix      = {2'b00, frame_pixels_i};
        w_words_ext = w_npix;
        case (color_depth_i)
            2'b00:   w_words_ext = (w_npix + (PIXCNT_W+2)'(3)) >> 2;
            2'b01:   w_words_ext = (w_npix + (PIXCNT_W+2)'(1)) >> 1;
            default: w_words_ext = w_npix;
        endcase
        w_words_init = w_words_ext[PIXCNT_W-1:0];
    end

    // Last lane index within a word (ppw-1).
    always_comb begin
        case (r_depth)
            2'b00:   w_lane_max = 2'd3;
            2'b01:   w_lane_max = 2'd1;
            default: w_lane_max = 2'd0;
        endcase
    end

    assign w_valid  = (r_cnt != 2'd0) && (r_pix_left != '0) && r_active;
    assign w_fire   = w_valid && pix_ready_i;
    assign w_last   = w_fire && (r_pix_left == PIXCNT_W'(1));
    assign w_pop    = w_fire && ((r_lane == w_lane_max) || w_last);
    assign w_ack    = (r_state == S_REQ) && wbm_ack_i;
    // An ack coinciding with start_i, or arriving after one, is old-frame data.
    assign w_push   = w_ack && !r_flush && !start_i && r_active;
    // In IDLE nothing is outstanding, so the FIFO occupancy alone gates a fetch.
    assign w_launch = (r_state == S_IDLE) && !start_i && r_active &&
                      (r_words_left != '0) && (r_cnt < 2'd2);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_launch) w_state_nxt = S_REQ;
            S_REQ:   if (wbm_ack_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= S_IDLE;
            r_req_adr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_launch) r_req_adr <= r_addr;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_flush <= 1'b0;
        end else if (start_i && (r_state == S_REQ) && !wbm_ack_i) begin
            r_flush <= 1'b1;
        end else if (w_ack) begin
            r_flush <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_depth      <= 2'b00;
            r_addr       <= '0;
            r_words_left <= '0;
            r_pix_left   <= '0;
            r_active     <= 1'b0;
            r_done       <= 1'b0;
            r_lane       <= 2'd0;
            r_cnt        <= 2'd0;
            r_rptr       <= 1'b0;
            r_wptr       <= 1'b0;
        end else if (start_i) begin
            r_depth      <= color_depth_i;
            r_addr       <= base_addr_i & ~ADDR_W'(3);
            r_words_left <= (color_depth_i == 2'b11) ? '0 : w_words_init;
            r_pix_left   <= frame_pixels_i;
            r_active     <= (color_depth_i != 2'b11) && (frame_pixels_i != '0);
            r_done       <= (color_depth_i != 2'b11) && (frame_pixels_i == '0);
            r_lane       <= 2'd0;
            r_cnt        <= 2'd0;
            r_rptr       <= 1'b0;
            r_wptr       <= 1'b0;
        end else begin
            if (w_push) begin
                r_addr       <= r_addr + ADDR_W'(4);
                r_words_left <= r_words_left - PIXCNT_W'(1);
            end
            if (w_fire) begin
                r_pix_left <= r_pix_left - PIXCNT_W'(1);
                r_lane     <= w_pop ? 2'd0 : r_lane + 2'd1;
            end
            if (w_last) begin
                r_active <= 1'b0;
                r_done   <= 1'b1;
                r_cnt    <= 2'd0;
                r_rptr   <= 1'b0;
                r_wptr   <= 1'b0;
            end else begin
                if (w_push) r_wptr <= ~r_wptr;
                if (w_pop)  r_rptr <= ~r_rptr;
                if (w_push && !w_pop)      r_cnt <= r_cnt + 2'd1;
                else if (w_pop && !w_push) r_cnt <= r_cnt - 2'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_fifo[0] <= '0;
            r_fifo[1] <= '0;
        end else if (w_push) begin
            r_fifo[r_wptr] <= wbm_dat_i;
        end
    end

    assign wbm_adr_o     = r_req_adr;
    assign wbm_cyc_o     = (r_state == S_REQ);
    assign wbm_stb_o     = wbm_cyc_o;
    assign wbm_we_o      = 1'b0;
    assign wbm_sel_o     = 4'b1111;
    assign mem_o         = r_fifo[r_rptr];
    assign mem_lsb_o     = r_lane;
    assign color_depth_o = r_depth;
    assign pix_valid_o   = w_valid;
    assign underrun_o    = pix_ready_i && !w_valid && r_active && (r_pix_left != '0);
    assign frame_done_o  = r_done;
    assign cfg_err_o     = (r_depth == 2'b11);

endmodule

// File: tb/tb_vga_pixel_fetch.sv
module tb_vga_pixel_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  depth;
    logic [31:0] base;
    logic [19:0] npix;
    logic [31:0] wb_adr;
    logic        wb_cyc, wb_stb, wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat;
    logic        wb_ack;
    logic [31:0] mem;
    logic [1:0]  lsb, cdepth;
    logic        pvalid, pready, underrun, done, cfg_err;

    int checks = 0;
    int errors = 0;
    int ack_dly = 0;
    int wcnt = 0;
    logic [31:0] rd_q [$];
    logic [31:0] px_mem_q [$];
    logic [1:0]  px_lsb_q [$];

    always #5 clk = ~clk;

    vga_pixel_fetch dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .color_depth_i(depth),
        .base_addr_i(base), .frame_pixels_i(npix),
        .wbm_adr_o(wb_adr), .wbm_cyc_o(wb_cyc), .wbm_stb_o(wb_stb), .wbm_we_o(wb_we),
        .wbm_sel_o(wb_sel), .wbm_dat_i(wb_dat), .wbm_ack_i(wb_ack),
        .mem_o(mem), .mem_lsb_o(lsb), .color_depth_o(cdepth),
        .pix_valid_o(pvalid), .pix_ready_i(pready), .underrun_o(underrun),
        .frame_done_o(done), .cfg_err_o(cfg_err)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Wishbone slave: ack after ack_dly wait cycles, data derived from address.
    assign wb_ack = wb_cyc && wb_stb && (wcnt >= ack_dly);
    assign wb_dat = memf(wb_adr);
    always @(posedge clk) begin
        if (!wb_cyc || wb_ack) wcnt <= 0;
        else                   wcnt <= wcnt + 1;
        if (wb_cyc && wb_ack) rd_q.push_back(wb_adr);
        if (pvalid && pready) begin
            px_mem_q.push_back(mem);
            px_lsb_q.push_back(lsb);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input logic [1:0] d, input logic [31:0] b,
                               input logic [19:0] p, input bit clr);
        if (clr) begin
            rd_q.delete();
            px_mem_q.delete();
            px_lsb_q.delete();
        end
        depth = d;
        base  = b;
        npix  = p;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int n = 0;
        while (done !== 1'b1 && n < maxc) begin
            step();
            n++;
        end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic check_reads(input string tag, input int n, input logic [31:0] b);
        chk({tag, "_nreads"}, rd_q.size(), n);
        for (int i = 0; i < n && i < rd_q.size(); i++)
            chk({tag, "_adr"}, rd_q[i], b + 32'(4 * i));
    endtask

    task automatic check_pix(input string tag, input int n, input logic [31:0] b, input int ppw);
        chk({tag, "_npix"}, px_mem_q.size(), n);
        for (int i = 0; i < n && i < px_mem_q.size(); i++) begin
            chk({tag, "_mem"}, px_mem_q[i], memf(b + 32'(4 * (i / ppw))));
            chk({tag, "_lsb"}, {30'd0, px_lsb_q[i]}, 32'(i % ppw));
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        depth  = 2'b00;
        base   = '0;
        npix   = '0;
        pready = 1'b0;
        step(2);
        chk("rst_cyc",   {31'd0, wb_cyc},  32'd0);
        chk("rst_stb",   {31'd0, wb_stb},  32'd0);
        chk("rst_we",    {31'd0, wb_we},   32'd0);
        chk("rst_sel",   {28'd0, wb_sel},  32'hF);
        chk("rst_valid", {31'd0, pvalid},  32'd0);
        chk("rst_done",  {31'd0, done},    32'd0);
        chk("rst_cfg",   {31'd0, cfg_err}, 32'd0);
        chk("rst_mem",   mem,              32'd0);
        rst_n = 1'b1;
        step();

        // 8bpp, 8 pixels, zero-wait ack
        pready  = 1'b1;
        ack_dly = 0;
        pulse_start(2'b00, 32'h1000, 20'd8, 1'b1);
        wait_done("t1_done", 100);
        check_reads("t1", 2, 32'h1000);
        check_pix("t1", 8, 32'h1000, 4);
        step(5);
        chk("t1_done_hold", {31'd0, done},     32'd1);
        chk("t1_no_under",  {31'd0, underrun}, 32'd0);
        chk("t1_idle",      {31'd0, wb_cyc},   32'd0);

        // 16bpp, 5 pixels, odd tail word
        pulse_start(2'b01, 32'h0, 20'd5, 1'b1);
        chk("t2_done_clr", {31'd0, done}, 32'd0);
        chk("t2_depth",    {30'd0, cdepth}, 32'd1);
        wait_done("t2_done", 100);
        check_reads("t2", 3, 32'h0);
        check_pix("t2", 5, 32'h0, 2);

        // 32bpp with consumer stalled: FIFO fills after two reads
        pready = 1'b0;
        pulse_start(2'b10, 32'h2000, 20'd4, 1'b1);
        step(30);
        check_reads("t3_stall", 2, 32'h2000);
        chk("t3_cyc_idle", {31'd0, wb_cyc}, 32'd0);
        chk("t3_valid",    {31'd0, pvalid}, 32'd1);
        chk("t3_head",     mem, memf(32'h2000));
        chk("t3_no_pix",   px_mem_q.size(), 0);
        pready = 1'b1;
        wait_done("t3_done", 100);
        check_reads("t3", 4, 32'h2000);
        check_pix("t3", 4, 32'h2000, 1);

        // Slow slave: underrun while the first read is outstanding
        ack_dly = 5;
        pulse_start(2'b10, 32'h3000, 20'd3, 1'b1);
        step(3);
        chk("t4_cyc_wait", {31'd0, wb_cyc},   32'd1);
        chk("t4_underrun", {31'd0, underrun}, 32'd1);
        chk("t4_novalid",  {31'd0, pvalid},   32'd0);
        wait_done("t4_done", 200);
        check_reads("t4", 3, 32'h3000);
        check_pix("t4", 3, 32'h3000, 1);
        chk("t4_under_end", {31'd0, underrun}, 32'd0);

        // Restart while a read is in flight: that word is dropped
        pulse_start(2'b10, 32'h4000, 20'd2, 1'b1);
        step(3);
        chk("t5_cyc_a", {31'd0, wb_cyc}, 32'd1);
        chk("t5_adr_a", wb_adr, 32'h4000);
        pulse_start(2'b10, 32'h5000, 20'd2, 1'b0);
        chk("t5_cyc_hold", {31'd0, wb_cyc}, 32'd1);
        chk("t5_adr_hold", wb_adr, 32'h4000);
        chk("t5_novalid",  {31'd0, pvalid}, 32'd0);
        wait_done("t5_done", 200);
        chk("t5_nreads", rd_q.size(), 3);
        if (rd_q.size() == 3) begin
            chk("t5_adr0", rd_q[0], 32'h4000);
            chk("t5_adr1", rd_q[1], 32'h5000);
            chk("t5_adr2", rd_q[2], 32'h5004);
        end
        check_pix("t5", 2, 32'h5000, 1);
        ack_dly = 0;

        // Invalid depth
        pulse_start(2'b11, 32'h6000, 20'd4, 1'b1);
        step(6);
        chk("t6_cfg_err", {31'd0, cfg_err}, 32'd1);
        chk("t6_depth",   {30'd0, cdepth},  32'd3);
        chk("t6_valid",   {31'd0, pvalid},  32'd0);
        chk("t6_done",    {31'd0, done},    32'd0);
        chk("t6_cyc",     {31'd0, wb_cyc},  32'd0);
        chk("t6_nreads",  rd_q.size(), 0);

        // Empty frame
        pulse_start(2'b00, 32'h7000, 20'd0, 1'b1);
        chk("t7_done",   {31'd0, done},    32'd1);
        chk("t7_cfg",    {31'd0, cfg_err}, 32'd0);
        step(6);
        chk("t7_nreads", rd_q.size(), 0);
        chk("t7_valid",  {31'd0, pvalid},  32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
